// File: rtl/fx2_pkg.sv
// Shared types and defaults for the FX2 EP6 slave-FIFO writer.
// Optional packet commit (PKTEND on idle timeout) is enabled by defining FX2_PKTEND_EN.
package fx2_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_WR_LOW   = 3'd2,
        S_WR_HIGH  = 3'd3,
        S_PKT_LOW  = 3'd4,
        S_PKT_HIGH = 3'd5
    } fx2_state_e;

    // FIFOADR[1:0] selecting endpoint 6
    localparam logic [1:0] EP6_ADDR = 2'b10;

    localparam int DEF_FIFO_AW     = 4;
    localparam int DEF_WR_LOW_CYC  = 3;
    localparam int DEF_WR_HIGH_CYC = 4;
    localparam int DEF_PKT_TIMEOUT = 1024;

    localparam int TIMER_W = 8;

    // Terminal value of a phase timer that starts at zero and lasts cyc cycles.
    function automatic logic [TIMER_W-1:0] phase_last(input int cyc);
        return TIMER_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/fx2_byte_fifo.sv
// Byte-wide synchronous FIFO, depth 2^AW, with full/empty from extended pointers.
module fx2_byte_fifo
    import fx2_pkg::*;
#(
    parameter int AW = DEF_FIFO_AW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array; no reset needed because the pointers qualify every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointers, one bit wider than the address to tell full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/fx2_ep6_writer.sv
// Fabric byte stream -> FX2 EP6 asynchronous slave-FIFO writes, throttled by FLAGB.
// Define FX2_PKTEND_EN to commit short packets with PKTEND after PKT_TIMEOUT idle cycles.
module fx2_ep6_writer
    import fx2_pkg::*;
#(
    parameter int FIFO_AW     = DEF_FIFO_AW,
    parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
`ifdef FX2_PKTEND_EN
    parameter int PKT_TIMEOUT = DEF_PKT_TIMEOUT,
`endif
    parameter int WR_HIGH_CYC = DEF_WR_HIGH_CYC
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  cy_fd_out,
    output logic        cy_fd_oe,
    input  logic        cy_to_fpga_CTL1_FLAGB,
    output logic        cy_from_fpga_RDY1_SLWR,
    output logic        cy_from_fpga_RDY0_SLRD,
    output logic        cy_from_fpga_A2_SLOE,
    output logic        cy_from_fpga_A4_FIFOADR0,
    output logic        cy_from_fpga_A5_FIFOADR1,
    output logic        cy_from_fpga_A6_PKTEND,
    output logic        busy,
    output logic [31:0] bytes_sent
);

    localparam logic [TIMER_W-1:0] LOW_LAST  = phase_last(WR_LOW_CYC);
    localparam logic [TIMER_W-1:0] HIGH_LAST = phase_last(WR_HIGH_CYC);

    fx2_state_e         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [7:0]         r_fd_out;
    logic               r_fd_oe;
    logic               r_slwr;
    logic               r_pktend;
    logic               r_ready_en;
    logic [31:0]        r_bytes_sent;
    logic               r_flag_meta;
    logic               r_full_n_s;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_rd_data;
    logic               w_wr_done;
    logic               w_pkt_due;

    assign w_push    = in_valid && in_ready;
    assign w_pop     = (r_state == S_IDLE) && !w_empty && r_full_n_s;
    assign w_wr_done = (r_state == S_WR_LOW) && (r_timer == LOW_LAST);

    fx2_byte_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (w_push),
        .wdata (in_data),
        .pop   (w_pop),
        .rdata (w_rd_data),
        .full  (w_full),
        .empty (w_empty)
    );

    // FLAGB arrives asynchronously from the FX2; two flops before use.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_flag_meta <= 1'b0;
            r_full_n_s  <= 1'b0;
        end else begin
            r_flag_meta <= cy_to_fpga_CTL1_FLAGB;
            r_full_n_s  <= r_flag_meta;
        end
    end

`ifdef FX2_PKTEND_EN
    localparam int IDLE_W = $clog2(PKT_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(PKT_TIMEOUT - 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_pend;
    logic              w_idle_cnting;

    assign w_idle_cnting = (r_state == S_IDLE) && w_empty && r_pend;
    assign w_pkt_due     = w_idle_cnting && r_full_n_s && (r_idle_cnt == IDLE_LAST);

    // Idle timer saturates at its terminal count while the FX2 reports full.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_idle_cnt <= '0;
            r_pend     <= 1'b0;
        end else begin
            if (w_push || !w_idle_cnting || w_pkt_due) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IDLE_LAST) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end else begin
                r_idle_cnt <= r_idle_cnt;
            end
            if (w_wr_done) begin
                r_pend <= 1'b1;
            end else if (w_pkt_due) begin
                r_pend <= 1'b0;
            end else begin
                r_pend <= r_pend;
            end
        end
    end
`else
    assign w_pkt_due = 1'b0;
`endif

    // Strobe sequencer: pop, data setup, SLWR low/high phases, optional PKTEND.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_fd_out     <= 8'h00;
            r_fd_oe      <= 1'b0;
            r_bytes_sent <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_fd_out <= w_rd_data;
                        r_fd_oe  <= 1'b1;
                        r_state  <= S_SETUP;
                    end else if (w_pkt_due) begin
                        r_fd_oe  <= 1'b0;
                        r_timer  <= '0;
                        r_state  <= S_PKT_LOW;
                    end else begin
                        r_fd_oe  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_timer <= '0;
                    r_state <= S_WR_LOW;
                end
                S_WR_LOW: begin
                    if (w_wr_done) begin
                        r_timer      <= '0;
                        r_bytes_sent <= r_bytes_sent + 32'd1;
                        r_state      <= S_WR_HIGH;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                S_WR_HIGH: begin
                    if (r_timer == HIGH_LAST) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                S_PKT_LOW: begin
                    if (r_timer == LOW_LAST) begin
                        r_timer <= '0;
                        r_state <= S_PKT_HIGH;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                S_PKT_HIGH: begin
                    if (r_timer == HIGH_LAST) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                default: begin
                    r_timer <= '0;
                    r_fd_oe <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pin strobes are decoded from state one cycle late, giving the FD setup margin.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_slwr     <= 1'b1;
            r_pktend   <= 1'b1;
            r_ready_en <= 1'b0;
        end else begin
            r_slwr     <= (r_state != S_WR_LOW);
`ifdef FX2_PKTEND_EN
            r_pktend   <= (r_state != S_PKT_LOW);
`else
            r_pktend   <= 1'b1;
`endif
            r_ready_en <= 1'b1;
        end
    end

    assign in_ready                 = r_ready_en && !w_full;
    assign busy                     = !w_empty || (r_state != S_IDLE);
    assign bytes_sent               = r_bytes_sent;
    assign cy_fd_out                = r_fd_out;
    assign cy_fd_oe                 = r_fd_oe;
    assign cy_from_fpga_RDY1_SLWR   = r_slwr;
    assign cy_from_fpga_A6_PKTEND   = r_pktend;
    assign cy_from_fpga_RDY0_SLRD   = 1'b1;
    assign cy_from_fpga_A2_SLOE     = 1'b1;
    assign cy_from_fpga_A4_FIFOADR0 = EP6_ADDR[0];
    assign cy_from_fpga_A5_FIFOADR1 = EP6_ADDR[1];

endmodule

// File: tb/tb_fx2_ep6_writer.sv
// Self-checking bench for fx2_ep6_writer; the PKTEND scenario follows FX2_PKTEND_EN.
module tb_fx2_ep6_writer;
    import fx2_pkg::*;

    localparam int DEPTH  = 1 << DEF_FIFO_AW;
    localparam int PERIOD = 2 + DEF_WR_LOW_CYC + DEF_WR_HIGH_CYC;

    logic        sys_clk  = 1'b0;
    logic        sys_rst  = 1'b1;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        flagb    = 1'b1;
    logic        in_ready, fd_oe, slwr, slrd, sloe, fa0, fa1, pktend, busy;
    logic [7:0]  fd_out;
    logic [31:0] bytes_sent;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] exp_sent = 32'd0;

    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          fall_cyc_q [$];
    int          low_w_q [$];
    int          pkt_fall_cyc_q [$];
    int          pkt_low_w_q [$];
    int          rise_cyc = 0;
    int          unstable = 0;
    int          blind_wr = 0;
    int          flag_low_run = 0;
    int          cur_low = 0;
    int          cur_pkt = 0;
    logic [7:0]  low_data = 8'h00;
    logic        prev_slwr = 1'b1;
    logic        prev_pkt = 1'b1;

    fx2_ep6_writer dut (
        .sys_clk                  (sys_clk),
        .sys_rst                  (sys_rst),
        .in_data                  (in_data),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .cy_fd_out                (fd_out),
        .cy_fd_oe                 (fd_oe),
        .cy_to_fpga_CTL1_FLAGB    (flagb),
        .cy_from_fpga_RDY1_SLWR   (slwr),
        .cy_from_fpga_RDY0_SLRD   (slrd),
        .cy_from_fpga_A2_SLOE     (sloe),
        .cy_from_fpga_A4_FIFOADR0 (fa0),
        .cy_from_fpga_A5_FIFOADR1 (fa1),
        .cy_from_fpga_A6_PKTEND   (pktend),
        .busy                     (busy),
        .bytes_sent               (bytes_sent)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Bus monitor: records every SLWR/PKTEND pulse, its width and the byte on FD.
    always @(negedge sys_clk) begin
        flag_low_run = flagb ? 0 : flag_low_run + 1;
        if (prev_slwr && !slwr) begin
            got_q.push_back(fd_out);
            fall_cyc_q.push_back(cyc);
            low_data = fd_out;
            cur_low  = 1;
            if (flag_low_run >= 5) blind_wr++;
            if (fd_oe !== 1'b1) unstable++;
        end else if (!slwr) begin
            cur_low++;
            if (fd_out !== low_data || fd_oe !== 1'b1) unstable++;
        end else if (!prev_slwr) begin
            low_w_q.push_back(cur_low);
            rise_cyc = cyc;
            if (fd_out !== low_data) unstable++;
        end
        if (prev_pkt && !pktend) begin
            pkt_fall_cyc_q.push_back(cyc);
            cur_pkt = 1;
        end else if (!pktend) begin
            cur_pkt++;
        end else if (!prev_pkt) begin
            pkt_low_w_q.push_back(cur_pkt);
        end
        prev_slwr = slwr;
        prev_pkt  = pktend;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_mon();
        exp_q.delete(); got_q.delete(); fall_cyc_q.delete(); low_w_q.delete();
        pkt_fall_cyc_q.delete(); pkt_low_w_q.delete();
        unstable = 0; blind_wr = 0;
    endtask

    task automatic push_byte(input logic [7:0] b, output int pc);
        int ok = 0;
        in_data = b; in_valid = 1'b1;
        for (int k = 0; k < 3000 && ok == 0; k++) begin
            if (in_ready === 1'b1) ok = 1;
            @(posedge sys_clk); #1;
        end
        pc = cyc; in_valid = 1'b0;
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL push_accept: byte %02h not accepted, in_ready=%b required 1", b, in_ready);
        end
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int ok = 0;
        for (int k = 0; k < limit && ok == 0; k++) begin
            if (busy === 1'b0 && slwr === 1'b1) ok = 1;
            else begin @(posedge sys_clk); #1; end
        end
        wait_cycles(2);
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", tag, busy, limit);
        end
    endtask

    task automatic check_stream(input string tag);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes, expected %0d", tag, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_data[%0d]: got %02h expected %02h", tag, i, got_q[i], exp_q[i]);
                end
            end
        end
        foreach (low_w_q[i]) begin
            checks++;
            if (low_w_q[i] != DEF_WR_LOW_CYC) begin
                errors++;
                $display("FAIL %s_slwr_width[%0d]: got %0d expected %0d", tag, i, low_w_q[i], DEF_WR_LOW_CYC);
            end
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL %s_fd_stable: %0d unstable samples, expected 0", tag, unstable);
        end
        checks++;
        if (bytes_sent !== exp_sent) begin
            errors++;
            $display("FAIL %s_bytes_sent: got %0d expected %0d", tag, bytes_sent, exp_sent);
        end
    endtask

    // Bytes accepted back-to-back before the buffer first reports full: one pop one cycle
    // after the first push, then one pop per byte period.
    function automatic int accepted_before_full();
        for (int k = 1; k < 200; k++) begin
            int pops = 0;
            for (int e = 2; e <= k; e += PERIOD) pops++;
            if (k - pops == DEPTH) return k;
        end
        return -1;
    endfunction

    task automatic test_reset();
        logic [31:0] got [10];
        logic [31:0] want [10];
        string       nm [10];
        sys_rst = 1'b1; flagb = 1'b1; in_valid = 1'b0;
        wait_cycles(3);
        got[0] = 32'(slwr);   want[0] = 32'd1; nm[0] = "rst_slwr";
        got[1] = 32'(pktend); want[1] = 32'd1; nm[1] = "rst_pktend";
        got[2] = 32'(slrd);   want[2] = 32'd1; nm[2] = "rst_slrd";
        got[3] = 32'(sloe);   want[3] = 32'd1; nm[3] = "rst_sloe";
        got[4] = {30'd0, fa1, fa0}; want[4] = 32'd2; nm[4] = "rst_fifoadr";
        got[5] = 32'(fd_out); want[5] = 32'd0; nm[5] = "rst_fd_out";
        got[6] = 32'(fd_oe);  want[6] = 32'd0; nm[6] = "rst_fd_oe";
        got[7] = 32'(in_ready); want[7] = 32'd0; nm[7] = "rst_in_ready";
        got[8] = 32'(busy);   want[8] = 32'd0; nm[8] = "rst_busy";
        got[9] = bytes_sent;  want[9] = 32'd0; nm[9] = "rst_bytes_sent";
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", nm[i], got[i], want[i]);
            end
        end
        sys_rst = 1'b0; exp_sent = 32'd0;
        wait_cycles(4);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        int pc;
        clear_mon();
        push_byte(8'h5A, pc);
        exp_q.push_back(8'h5A); exp_sent++;
        wait_idle(100, "single");
        check_stream("single");
        checks++;
        if (fall_cyc_q.size() != 1 || fall_cyc_q[0] - pc != 3) begin
            errors++;
            $display("FAIL single_latency: falls=%0d first at +%0d cycles, expected 1 at +3",
                     fall_cyc_q.size(), (fall_cyc_q.size() > 0) ? fall_cyc_q[0] - pc : -1);
        end
    endtask

    task automatic test_back_to_back();
        int pc;
        int first_block = -1;
        clear_mon();
        for (int i = 0; i < 20; i++) begin
            if (in_ready !== 1'b1 && first_block < 0) first_block = i;
            push_byte(8'(i), pc);
            exp_q.push_back(8'(i)); exp_sent++;
        end
        wait_idle(20 * PERIOD + 60, "b2b");
        check_stream("b2b");
        checks++;
        if (first_block != accepted_before_full()) begin
            errors++;
            $display("FAIL b2b_ready_drop: in_ready fell after %0d bytes, expected %0d",
                     first_block, accepted_before_full());
        end
        for (int i = 1; i < fall_cyc_q.size(); i++) begin
            checks++;
            if (fall_cyc_q[i] - fall_cyc_q[i-1] != PERIOD) begin
                errors++;
                $display("FAIL b2b_period[%0d]: got %0d cycles expected %0d",
                         i, fall_cyc_q[i] - fall_cyc_q[i-1], PERIOD);
            end
        end
    endtask

    task automatic test_flag_hold();
        int pc;
        int rc;
        int found = 0;
        int dly = -1;
        logic [7:0] b;
        clear_mon();
        flagb = 1'b0;
        wait_cycles(3);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            push_byte(b, pc);
            exp_q.push_back(b); exp_sent++;
        end
        wait_cycles(30);
        checks++;
        if (got_q.size() != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flag_hold: %0d strobes busy=%b while full, expected 0 strobes busy=1",
                     got_q.size(), busy);
        end
        flagb = 1'b1; rc = cyc;
        for (int k = 0; k < 10 && found == 0; k++) begin
            if (fd_oe === 1'b1) begin found = 1; dly = cyc - rc; end
            else begin @(posedge sys_clk); #1; end
        end
        checks++;
        if (found == 0 || dly > 3) begin
            errors++;
            $display("FAIL flag_resume: write started after %0d cycles, expected <= 3", dly);
        end
        wait_idle(100, "flag");
        check_stream("flag");
    endtask

    task automatic test_random();
        int done = 0;
        clear_mon();
        fork
            begin
                int pc;
                logic [7:0] b;
                for (int i = 0; i < 40; i++) begin
                    wait_cycles($urandom_range(0, 3));
                    b = 8'($urandom);
                    push_byte(b, pc);
                    exp_q.push_back(b); exp_sent++;
                end
                done = 1;
            end
            begin
                while (done == 0) begin
                    flagb = ($urandom_range(0, 3) != 0);
                    wait_cycles($urandom_range(3, 25));
                end
                flagb = 1'b1;
            end
        join
        wait_idle(DEPTH * PERIOD + 100, "rand");
        check_stream("rand");
        checks++;
        if (blind_wr != 0) begin
            errors++;
            $display("FAIL rand_full_respect: %0d strobes while FX2 full, expected 0", blind_wr);
        end
    endtask

    task automatic test_pktend();
        int pc;
        clear_mon();
        push_byte(8'hC3, pc);
        exp_q.push_back(8'hC3); exp_sent++;
        wait_idle(100, "pkt");
`ifdef FX2_PKTEND_EN
        for (int k = 0; k < DEF_PKT_TIMEOUT + 100 && pkt_low_w_q.size() == 0; k++) wait_cycles(1);
        checks++;
        if (pkt_fall_cyc_q.size() != 1 || pkt_low_w_q.size() != 1) begin
            errors++;
            $display("FAIL pktend_count: got %0d pulses, expected 1", pkt_low_w_q.size());
        end else begin
            checks++;
            if (pkt_fall_cyc_q[0] - rise_cyc != DEF_PKT_TIMEOUT + DEF_WR_HIGH_CYC) begin
                errors++;
                $display("FAIL pktend_delay: got %0d expected %0d", pkt_fall_cyc_q[0] - rise_cyc,
                         DEF_PKT_TIMEOUT + DEF_WR_HIGH_CYC);
            end
            checks++;
            if (pkt_low_w_q[0] != DEF_WR_LOW_CYC) begin
                errors++;
                $display("FAIL pktend_width: got %0d expected %0d", pkt_low_w_q[0], DEF_WR_LOW_CYC);
            end
        end
`else
        wait_cycles(DEF_PKT_TIMEOUT + 200);
        checks++;
        if (pkt_fall_cyc_q.size() != 0 || pktend !== 1'b1) begin
            errors++;
            $display("FAIL pktend_held: got %0d pulses pktend=%b, expected 0 pulses and 1",
                     pkt_fall_cyc_q.size(), pktend);
        end
`endif
        check_stream("pkt");
    endtask

    task automatic test_wrap();
        int pc;
        clear_mon();
        force dut.r_bytes_sent = 32'hFFFF_FFFF;
        wait_cycles(1);
        release dut.r_bytes_sent;
        push_byte(8'hE7, pc);
        exp_q.push_back(8'hE7); exp_sent = 32'd0;
        wait_idle(100, "wrap");
        check_stream("wrap");
    endtask

    task automatic test_reset_mid_strobe();
        int pc;
        int found = 0;
        clear_mon();
        push_byte(8'h11, pc);
        push_byte(8'h22, pc);
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (slwr === 1'b0) found = 1;
            else begin @(posedge sys_clk); #1; end
        end
        sys_rst = 1'b1;
        wait_cycles(1);
        checks++;
        if (found == 0 || slwr !== 1'b1 || busy !== 1'b0 || bytes_sent !== 32'd0) begin
            errors++;
            $display("FAIL midrst_state: strobe_seen=%0d slwr=%b busy=%b bytes_sent=%0d, expected 1 1 0 0",
                     found, slwr, busy, bytes_sent);
        end
        sys_rst = 1'b0; exp_sent = 32'd0;
        wait_cycles(40);
        checks++;
        if (got_q.size() != 1 || busy !== 1'b0 || bytes_sent !== 32'd0 || fd_oe !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flush: strobes=%0d busy=%b bytes_sent=%0d oe=%b, expected 1 0 0 0",
                     got_q.size(), busy, bytes_sent, fd_oe);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flag_hold();
        test_random();
        test_pktend();
        test_wrap();
        test_reset_mid_strobe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
